// File: rtl/core_run_ctrl_if.sv
// Run-control bus between the harness (master) and core_run_ctrl (slave):
// run start, core retire/halt observation, reset to the core and run verdict.
interface core_run_ctrl_if #(
    parameter int CNT_W        = 32,
    parameter int RETIRE_LANES = 1
);
    logic                    start;
    logic [RETIRE_LANES-1:0] retire_valid;
    logic                    halt;
    logic [31:0]             halt_code;
    logic                    core_rst_;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    timeout;
    logic                    hang;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [CNT_W-1:0]        retire_cnt;
    logic [31:0]             exit_code;

    modport master (
        output start, retire_valid, halt, halt_code,
        input  core_rst_, busy, done, pass, timeout, hang,
        input  cycle_cnt, retire_cnt, exit_code
    );

    modport slave (
        input  start, retire_valid, halt, halt_code,
        output core_rst_, busy, done, pass, timeout, hang,
        output cycle_cnt, retire_cnt, exit_code
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Sequences core reset, counts RUN cycles/retires, ends a run on halt, timeout or hang.
// All outputs registered; core_rst_ rises RST_CYCLES edges after start is sampled; no backpressure.
module core_run_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 100000,
    parameter int STALL_LIMIT  = 256,
    parameter int RETIRE_LANES = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    core_run_ctrl_if.slave   bus
);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int SCW = $clog2(STALL_LIMIT + 1);

    localparam logic [RCW-1:0]   RST_LAST   = RCW'(RST_CYCLES - 1);
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [SCW-1:0]   STALL_LAST = SCW'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [RCW-1:0]   rst_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic [SCW-1:0]   stall_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [31:0]      exit_code;
    logic             core_rst_q;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             hang;

    logic [2:0]       pop;
    logic [CNT_W:0]   ret_sum;
    logic [CNT_W-1:0] ret_next;
    logic             any_ret;

    always_comb begin
        pop = '0;
        for (int i = 0; i < RETIRE_LANES; i++) begin
            pop = pop + 3'(bus.retire_valid[i]);
        end
        any_ret  = |bus.retire_valid;
        ret_sum  = {1'b0, retire_cnt} + (CNT_W+1)'(pop);
        ret_next = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            drain_cnt  <= '0;
            stall_cnt  <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            exit_code  <= '0;
            core_rst_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            hang       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state      <= S_RESET;
                        rst_cnt    <= '0;
                        drain_cnt  <= '0;
                        stall_cnt  <= '0;
                        cycle_cnt  <= '0;
                        retire_cnt <= '0;
                        exit_code  <= '0;
                        core_rst_q <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        hang       <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= S_RUN;
                        core_rst_q <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                S_RUN: begin
                    cycle_cnt  <= cycle_cnt + CNT_W'(1);
                    retire_cnt <= ret_next;
                    stall_cnt  <= any_ret ? '0 : stall_cnt + SCW'(1);
                    // halt outranks timeout, which outranks hang, on the same cycle
                    if (bus.halt) begin
                        exit_code <= bus.halt_code;
                        if (DRAIN_CYCLES == 0) begin
                            state      <= S_DONE;
                            core_rst_q <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            pass       <= (bus.halt_code == 32'd0);
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else if (cycle_cnt == CYC_LAST) begin
                        state      <= S_DONE;
                        core_rst_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                    end else if (!any_ret && stall_cnt == STALL_LAST) begin
                        state      <= S_DONE;
                        core_rst_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        hang       <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // only reachable through halt, so the verdict rests on exit_code alone
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= S_DONE;
                        core_rst_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (exit_code == 32'd0);
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_rst_  = core_rst_q;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.timeout    = timeout;
    assign bus.hang       = hang;
    assign bus.cycle_cnt  = cycle_cnt;
    assign bus.retire_cnt = retire_cnt;
    assign bus.exit_code  = exit_code;
endmodule
